// File: rtl/out_port_fifo.sv
// Output-port FIFO: queues values written to register O for a slow consumer.
// Ports: clk, reset (async, active-high); wen/din capture side;
//   out_valid/out_ready/out_data first-word-fall-through read side;
//   count/full/empty status; overflow sticky drop flag with ovf_clr;
//   last_val holds the most recently accepted value.
module out_port_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         din,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         last_val
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] last_q, last_d;

  logic is_empty, is_full;
  logic pop, push, drop;

  // Status comes from the occupancy counter; pointers alone are
  // ambiguous when they are equal.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  assign pop  = !is_empty && out_ready;
  // A full FIFO still accepts when a slot frees in the same cycle.
  assign push = wen && (!is_full || pop);
  assign drop = wen && is_full && !pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      last_d   = din;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over clear so a drop is never lost.
    if (drop)
      ovf_d = 1'b1;
    else if (ovf_clr)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  // Storage is never reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= din;
  end

  assign out_valid = !is_empty;
  assign out_data  = is_empty ? '0 : mem[rd_ptr_q];
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = ovf_q;
  assign last_val  = last_q;

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: directed stimulus, queue scoreboard
// with an independent pop monitor, plus status checks.
module tb_out_port_fifo;

  logic       clk = 0;
  logic       reset = 0;
  logic       wen = 0;
  logic [3:0] din = 0;
  logic       out_ready = 0;
  logic       ovf_clr = 0;
  logic       out_valid;
  logic [3:0] out_data;
  logic [2:0] count;
  logic       full, empty, overflow;
  logic [3:0] last_val;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  out_port_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wen(wen), .din(din),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .ovf_clr(ovf_clr),
    .last_val(last_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are stable across the falling edge before the rising
  // edge that acts on them, so a pop is visible here.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0d expected none",
                 out_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(out_data) != e) begin
          errors++;
          $display("FAIL pop_order: got %0d expected %0d",
                   out_data, e);
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic [3:0] d,
                     input logic r, input logic c);
    wen = w; din = d; out_ready = r; ovf_clr = c;
    @(posedge clk);
    #1;
    wen = 0; out_ready = 0; ovf_clr = 0;
  endtask

  task automatic push(input logic [3:0] d);
    exp_q.push_back(int'(d));
    cyc(1, d, 0, 0);
  endtask

  initial begin
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_last", int'(last_val), 0);
    reset = 0;

    push(5);
    chk("one_valid", int'(out_valid), 1);
    chk("one_data", int'(out_data), 5);
    chk("one_count", int'(count), 1);
    chk("one_last", int'(last_val), 5);
    cyc(0, 0, 1, 0);
    chk("one_empty", int'(empty), 1);

    for (int i = 1; i <= 4; i++) push(4'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 4);
    cyc(1, 9, 0, 0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_count", int'(count), 4);
    chk("drop_last", int'(last_val), 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_full", int'(full), 0);
    cyc(0, 0, 1, 0);
    chk("empty_pop_count", int'(count), 0);

    for (int i = 10; i <= 13; i++) push(4'(i));
    cyc(1, 9, 0, 1);
    chk("set_wins", int'(overflow), 1);
    chk("set_wins_count", int'(count), 4);
    cyc(0, 0, 0, 1);
    chk("ovf_clear", int'(overflow), 0);

    exp_q.push_back(7);
    cyc(1, 7, 1, 0);
    chk("fullpp_ovf", int'(overflow), 0);
    chk("fullpp_count", int'(count), 4);
    chk("fullpp_last", int'(last_val), 7);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk("fullpp_empty", int'(empty), 1);

    push(1);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(i + 2);
      cyc(1, 4'(i + 2), 1, 0);
      chk("pp_count", int'(count), 1);
    end
    cyc(0, 0, 1, 0);
    chk("pp_empty", int'(empty), 1);

    push(3); push(4); push(5);
    chk("pre_rst_count", int'(count), 3);
    #2 reset = 1;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_last", int'(last_val), 0);
    @(posedge clk);
    #1 reset = 0;
    push(6);
    chk("post_rst_data", int'(out_data), 6);
    chk("post_rst_count", int'(count), 1);
    cyc(0, 0, 1, 0);
    chk("post_rst_empty", int'(empty), 1);

    @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/out_port_fifo.md
OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the data width of one captured output value.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of entries (a power of two, >= 2).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: wen  input  1  capture strobe, driven by the core's register-O write enable (enO).
REQ-006 Port: din  input  WIDTH  value being written into register O (the core's regA).
REQ-007 Port: out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-008 Port: out_valid  output  1  out_data holds a valid queued value.
REQ-009 Port: out_data  output  WIDTH  oldest queued value.
REQ-010 Port: count  output  $clog2(DEPTH)+1  number of queued entries, 0..DEPTH.
REQ-011 Port: full  output  1  count == DEPTH.
REQ-012 Port: empty  output  1  count == 0.
REQ-013 Port: overflow  output  1  sticky flag: a capture was dropped.
REQ-014 Port: ovf_clr  input  1  synchronous clear of overflow.
REQ-015 Port: last_val  output  WIDTH  most recently accepted value, for LED/display hold.

Function
REQ-016 The block SHALL be a first-word-fall-through FIFO: out_valid = !empty; out_data = entry at the read pointer when out_valid = 1, all zeros when empty.
REQ-017 Pop SHALL occur on a rising edge where out_valid = 1 and out_ready = 1; the read pointer advances by 1 modulo DEPTH.
REQ-018 Push SHALL occur on a rising edge where wen = 1 and (full = 0 or pop occurs in the same cycle); din is written at the write pointer, which advances by 1 modulo DEPTH.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; push only increments count, pop only decrements it.
REQ-020 Push into an empty FIFO SHALL make out_valid = 1 on the next cycle; there is no same-cycle bypass from din to out_data.
REQ-021 When empty = 1, out_ready SHALL have no effect (no pop, no pointer movement).
REQ-022 wen = 1 with full = 1 and no pop SHALL drop din, leave pointers, count and last_val unchanged, and set overflow to 1 on that edge.
REQ-023 overflow SHALL remain 1 until ovf_clr = 1 or reset; if ovf_clr and a new drop occur in the same cycle, overflow SHALL be 1 (set wins).
REQ-024 last_val SHALL load din on every accepted push and hold otherwise.
REQ-025 Pointer wrap-around SHALL be transparent: data order is preserved across any number of wraps.
REQ-026 full and empty SHALL be derived from count, never from pointer equality alone, and SHALL never both be 1.
REQ-027 All outputs except out_data SHALL be registered or direct decodes of registered state; there SHALL be no combinational path from wen or din to any output.

Reset
REQ-028 While reset = 1 (asynchronous, effective immediately): read pointer = 0, write pointer = 0, count = 0, empty = 1, full = 0, out_valid = 0, out_data = 0, overflow = 0, last_val = 0.
REQ-029 Storage array contents SHALL NOT be reset; they are unobservable while empty.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; the first push after reset release SHALL be the first value popped.

Verification
REQ-031 Reset, then wen = 1 with din = 5 for one cycle, out_ready = 0 -> next cycle out_valid = 1, out_data = 5, count = 1, last_val = 5.
REQ-032 Push 1, 2, 3, 4 with out_ready = 0 -> full = 1, count = 4; push 9 -> overflow = 1, count = 4; pop all -> 1, 2, 3, 4 in order, empty = 1.
REQ-033 With the FIFO full, wen = 1 with din = 7 and out_ready = 1 in the same cycle -> no overflow, count stays 4, 7 is the last value popped.
REQ-034 Run 10 push/pop cycles with simultaneous push and pop on a non-empty FIFO -> count constant, output order equals input order across pointer wrap.
REQ-035 overflow = 1, ovf_clr = 1 in the same cycle as another dropped push -> overflow stays 1; ovf_clr alone on the next cycle -> overflow = 0.
REQ-036 Assert reset with count = 3 -> outputs take the REQ-028 values immediately; after release, push 6 -> first popped value is 6.
